// File: rtl/qsys_multi_interval_timer.sv
// qsys_multi_interval_timer
// NUM_CH independent interval timers behind one 16-bit Avalon-MM slave port.
// Each channel has a down-counter, a period register, a 16-bit prescaler,
// one-shot/continuous mode, a snapshot register and a maskable timeout IRQ.
// Address layout is {channel, reg[2:0]}. Channel slots beyond NUM_CH read as
// zero and ignore writes.
module qsys_multi_interval_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999,
    localparam int AW          = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [AW-1:0]     address,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic [NUM_CH-1:0] irq_ch,
    output logic              irq
);

    // Register offsets inside a channel slot
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam logic [2:0] REG_PRESC    = 3'd6;
    localparam logic [2:0] REG_PENDING  = 3'd7;

    // CONTROL bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);

    // Shared address decode
    logic [AW-1:0] ch_field;
    logic [2:0]    reg_sel;
    logic          wr_en;

    assign ch_field = address >> 3;
    assign reg_sel  = address[2:0];
    assign wr_en    = chipselect & ~write_n;

    // Per-channel results gathered for the shared read path and IRQ outputs
    logic [NUM_CH-1:0]       to_vec;
    logic [NUM_CH-1:0][15:0] rd_word;
    logic [15:0]             pending;
    logic [15:0]             readdata_next;

    // PENDING word: TO of every channel, zero-extended to the bus width
    always_comb begin
        pending                = '0;
        pending[NUM_CH-1:0]    = to_vec;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] counter_reg;
        logic [CNT_W-1:0] period_reg;
        logic [CNT_W-1:0] snap_reg;
        logic [15:0]      presc_reg;
        logic [15:0]      presc_cnt_reg;
        logic [3:0]       ctrl_reg;
        logic             run_reg;
        logic             to_reg;
        logic             reload_reg;

        logic             sel;
        logic             wr_status;
        logic             wr_control;
        logic             wr_period_l;
        logic             wr_period_h;
        logic             wr_snap;
        logic             wr_presc;
        logic             tick;
        logic             timeout;
        logic [31:0]      period_w;
        logic [31:0]      snap_w;
        logic [15:0]      word;

        assign sel = (ch_field == AW'(gi));

        // Per-register write strobes for this channel
        always_comb begin
            wr_status   = 1'b0;
            wr_control  = 1'b0;
            wr_period_l = 1'b0;
            wr_period_h = 1'b0;
            wr_snap     = 1'b0;
            wr_presc    = 1'b0;
            if (wr_en && sel) begin
                case (reg_sel)
                    REG_STATUS:   wr_status   = 1'b1;
                    REG_CONTROL:  wr_control  = 1'b1;
                    REG_PERIOD_L: wr_period_l = 1'b1;
                    REG_PERIOD_H: wr_period_h = 1'b1;
                    REG_SNAP_L:   wr_snap     = 1'b1;
                    REG_SNAP_H:   wr_snap     = 1'b1;
                    REG_PRESC:    wr_presc    = 1'b1;
                    default:      ;
                endcase
            end
        end

        // A tick is one prescaled count step; a pending reload suppresses it
        assign tick    = run_reg && (presc_cnt_reg == presc_reg);
        assign timeout = tick && !reload_reg && (counter_reg == '0);

        // Configuration registers: period, prescaler, control and snapshot
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                period_reg <= RST_PERIOD;
                presc_reg  <= '0;
                ctrl_reg   <= '0;
                snap_reg   <= '0;
                reload_reg <= 1'b0;
            end else begin
                // A period write arms a one-cycle reload of the counter
                reload_reg <= wr_period_l | wr_period_h;
                if (wr_period_l) begin
                    period_reg[15:0] <= writedata;
                end
                if (wr_period_h) begin
                    period_reg[CNT_W-1:16] <= writedata[CNT_W-17:0];
                end
                if (wr_presc) begin
                    presc_reg <= writedata;
                end
                if (wr_control) begin
                    ctrl_reg <= writedata[3:0];
                end
                // Snapshot captures the counter value present at the write edge
                if (wr_snap) begin
                    snap_reg <= counter_reg;
                end
            end
        end

        // Counter, prescaler and RUN; START overrides reload/STOP/one-shot end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                counter_reg   <= RST_PERIOD;
                presc_cnt_reg <= '0;
                run_reg       <= 1'b0;
            end else begin
                if (reload_reg) begin
                    counter_reg   <= period_reg;
                    presc_cnt_reg <= '0;
                    run_reg       <= 1'b0;
                end else if (tick) begin
                    presc_cnt_reg <= '0;
                    if (counter_reg == '0) begin
                        counter_reg <= period_reg;
                        run_reg     <= ctrl_reg[CTRL_CONT];
                    end else begin
                        counter_reg <= counter_reg - CNT_W'(1);
                    end
                end else if (run_reg) begin
                    presc_cnt_reg <= presc_cnt_reg + 16'd1;
                end

                if (wr_control) begin
                    if (writedata[CTRL_START]) begin
                        run_reg       <= 1'b1;
                        presc_cnt_reg <= '0;
                    end else if (writedata[CTRL_STOP]) begin
                        run_reg <= 1'b0;
                    end
                end
            end
        end

        // Timeout flag: a timeout in the same cycle as a clear is kept
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                to_reg <= 1'b0;
            end else if (timeout) begin
                to_reg <= 1'b1;
            end else if (wr_status) begin
                to_reg <= 1'b0;
            end
        end

        // Read word for this channel's register slot
        always_comb begin
            period_w             = '0;
            period_w[CNT_W-1:0]  = period_reg;
            snap_w               = '0;
            snap_w[CNT_W-1:0]    = snap_reg;
            word                 = '0;
            case (reg_sel)
                REG_STATUS:   word = {14'b0, run_reg, to_reg};
                REG_CONTROL:  word = {12'b0, ctrl_reg};
                REG_PERIOD_L: word = period_w[15:0];
                REG_PERIOD_H: word = period_w[31:16];
                REG_SNAP_L:   word = snap_w[15:0];
                REG_SNAP_H:   word = snap_w[31:16];
                REG_PRESC:    word = presc_reg;
                REG_PENDING:  word = pending;
                default:      word = '0;
            endcase
        end

        assign rd_word[gi] = sel ? word : 16'h0000;
        assign to_vec[gi]  = to_reg;
        assign irq_ch[gi]  = to_reg & ctrl_reg[CTRL_ITO];
    end

    // Combine channel read words; unmatched channel slots contribute zero
    always_comb begin
        readdata_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            readdata_next = readdata_next | rd_word[i];
        end
    end

    // Registered read data, refreshed every clock from the current address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= readdata_next;
        end
    end

    assign irq = |irq_ch;

endmodule
